// File: rtl/char_mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one synchronous-read
// character memory between the transform fetch and the beacon reader.
module char_mem_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_BURST   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        owner
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic [MEM_LATENCY-1:0] vld_q, vld_d;
  logic [MEM_LATENCY-1:0] id_q, id_d;
  logic                   acc;
  logic                   cur;
  logic                   cur_req;
  logic                   oth_req;
  logic                   done;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    acc      = 1'b0;
    done     = 1'b0;
    mem_addr = '0;
    cur      = (state_q == GRANT1);
    cur_req  = cur ? r1_req : r0_req;
    oth_req  = cur ? r0_req : r1_req;
    unique case (state_q)
      IDLE: begin
        if (r0_req && r1_req)
          state_d = last_q ? GRANT0 : GRANT1;
        else if (r0_req)
          state_d = GRANT0;
        else if (r1_req)
          state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        mem_addr = cur ? r1_addr : r0_addr;
        acc      = cur_req;
        done     = !cur_req || (cnt_q == CW'(MAX_BURST - 1));
        cnt_d    = cnt_q + CW'(acc);
        // Re-arbitrate in the same cycle so ownership hands over bubble-free
        if (done) begin
          last_d = cur;
          cnt_d  = '0;
          if (oth_req)
            state_d = cur ? GRANT0 : GRANT1;
          else if (!cur_req)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    vld_d    = vld_q << 1;
    vld_d[0] = acc;
    id_d     = id_q << 1;
    id_d[0]  = cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      vld_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
    end
  end

  assign r0_gnt    = (state_q == GRANT0);
  assign r1_gnt    = (state_q == GRANT1);
  assign owner     = state_q;
  assign r0_rvalid = vld_q[MEM_LATENCY-1] & ~id_q[MEM_LATENCY-1];
  assign r1_rvalid = vld_q[MEM_LATENCY-1] &  id_q[MEM_LATENCY-1];
  assign r0_rdata  = mem_dout;
  assign r1_rdata  = mem_dout;

endmodule

// File: tb/tb_char_mem_arbiter.sv
// Bench for char_mem_arbiter: two instances (latency 1 / burst 8 and
// latency 3 / burst 1) against a transaction-level model and scoreboard.
module tb_char_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2][2];
  logic [9:0]  addr  [2][2];
  logic        gnt   [2][2];
  logic        rv    [2][2];
  logic [15:0] rdata [2][2];
  logic [9:0]  maddr [2];
  logic [15:0] dout  [2];
  logic [1:0]  own   [2];
  logic [9:0]  ap_a;
  logic [9:0]  ap_b  [3];

  always #5 clk = ~clk;

  char_mem_arbiter #(
    .ADDR_W(10), .DATA_W(16), .MEM_LATENCY(1), .MAX_BURST(8)
  ) u_a (
    .clk(clk), .rst(rst),
    .r0_req(req[0][0]), .r0_addr(addr[0][0]), .r0_gnt(gnt[0][0]),
    .r0_rvalid(rv[0][0]), .r0_rdata(rdata[0][0]),
    .r1_req(req[0][1]), .r1_addr(addr[0][1]), .r1_gnt(gnt[0][1]),
    .r1_rvalid(rv[0][1]), .r1_rdata(rdata[0][1]),
    .mem_addr(maddr[0]), .mem_dout(dout[0]), .owner(own[0])
  );

  char_mem_arbiter #(
    .ADDR_W(10), .DATA_W(16), .MEM_LATENCY(3), .MAX_BURST(1)
  ) u_b (
    .clk(clk), .rst(rst),
    .r0_req(req[1][0]), .r0_addr(addr[1][0]), .r0_gnt(gnt[1][0]),
    .r0_rvalid(rv[1][0]), .r0_rdata(rdata[1][0]),
    .r1_req(req[1][1]), .r1_addr(addr[1][1]), .r1_gnt(gnt[1][1]),
    .r1_rvalid(rv[1][1]), .r1_rdata(rdata[1][1]),
    .mem_addr(maddr[1]), .mem_dout(dout[1]), .owner(own[1])
  );

  function automatic logic [15:0] memval(input logic [9:0] a);
    if (a == 10'd5) return 16'h5C66;
    return {a[7:0], ~a[7:0]} ^ 16'h1234;
  endfunction

  // Synchronous-read memories with 1 and 3 cycles of latency
  always @(posedge clk) begin
    ap_a    <= maddr[0];
    ap_b[0] <= maddr[1];
    ap_b[1] <= ap_b[0];
    ap_b[2] <= ap_b[1];
  end
  assign dout[0] = memval(ap_a);
  assign dout[1] = memval(ap_b[2]);

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic int mb_of(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  typedef struct {
    int own;
    int beats;
    int last;
  } mdl_t;
  typedef struct {
    int          inst;
    int          id;
    logic [15:0] data;
    int          due;
  } ret_t;
  typedef struct {
    logic        q0;
    logic [9:0]  a0;
    logic        q1;
    logic [9:0]  a1;
    logic        g0;
    logic        g1;
    logic [1:0]  ow;
    logic [9:0]  ma;
    logic        v0;
    logic        v1;
    logic [15:0] rd;
  } vec_t;

  mdl_t m [2];
  ret_t sb [$];
  int   log_a [$];
  int   log_b [$];
  int   rvc [2][2];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  vec_t tbl [9];

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h",
               name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m[i] = '{-1, 0, 1};
    sb.delete();
  endtask

  task automatic set_in(input int i, input logic q0, input logic [9:0] a0,
                        input logic q1, input logic [9:0] a1);
    req[i][0]  = q0;
    addr[i][0] = a0;
    req[i][1]  = q1;
    addr[i][1] = a1;
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_gnt0", i, gnt[i][0], 0);
      check("rst_gnt1", i, gnt[i][1], 0);
      check("rst_owner", i, own[i], 0);
      check("rst_rv0", i, rv[i][0], 0);
      check("rst_rv1", i, rv[i][1], 0);
      check("rst_maddr", i, maddr[i], 0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: compare at the falling edge, then advance the model
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int          o;
      int          v;
      logic        e0, e1, rq, ro, dn;
      logic [15:0] ed;
      o  = m[i].own;
      e0 = 1'b0;
      e1 = 1'b0;
      ed = '0;
      check("gnt0", i, gnt[i][0], o == 0);
      check("gnt1", i, gnt[i][1], o == 1);
      check("owner", i, own[i], (o < 0) ? 0 : (o == 0) ? 1 : 2);
      if (o < 0) check("mem_addr", i, maddr[i], 0);
      else       check("mem_addr", i, maddr[i], addr[i][o]);
      for (int k = 0; k < sb.size(); k++) begin
        if (sb[k].inst == i && sb[k].due == cyc) begin
          if (sb[k].id == 1) e1 = 1'b1;
          else               e0 = 1'b1;
          ed = sb[k].data;
          sb.delete(k);
          break;
        end
      end
      check("rvalid0", i, rv[i][0], e0);
      check("rvalid1", i, rv[i][1], e1);
      if (e0) check("rdata0", i, rdata[i][0], ed);
      if (e1) check("rdata1", i, rdata[i][1], ed);
      if (rv[i][0]) rvc[i][0]++;
      if (rv[i][1]) rvc[i][1]++;
      v = (gnt[i][0] && req[i][0]) ? 0 :
          (gnt[i][1] && req[i][1]) ? 1 : -1;
      if (i == 0) log_a.push_back(v);
      else        log_b.push_back(v);
      if (o < 0) begin
        if (req[i][0] && req[i][1]) m[i].own = 1 - m[i].last;
        else if (req[i][0])         m[i].own = 0;
        else if (req[i][1])         m[i].own = 1;
      end else begin
        rq = req[i][o];
        ro = req[i][1-o];
        dn = !rq || (m[i].beats + 1 == mb_of(i));
        if (rq) begin
          sb.push_back('{i, o, memval(addr[i][o]), cyc + lat_of(i)});
          m[i].beats++;
        end
        if (dn) begin
          m[i].last  = o;
          m[i].beats = 0;
          m[i].own   = ro ? 1 - o : rq ? o : -1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int nb;
    int gap;
    tbl[0] = '{1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0};
    tbl[1] = '{1, 5, 0, 0, 1, 0, 1, 5, 0, 0, 16'h0};
    tbl[2] = '{0, 5, 0, 0, 1, 0, 1, 5, 1, 0, 16'h5C66};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0};
    tbl[4] = '{1, 7, 1, 9, 0, 0, 0, 0, 0, 0, 16'h0};
    tbl[5] = '{1, 7, 1, 9, 0, 1, 2, 9, 0, 0, 16'h0};
    tbl[6] = '{1, 7, 0, 9, 0, 1, 2, 9, 0, 1, memval(10'd9)};
    tbl[7] = '{0, 7, 0, 9, 1, 0, 1, 7, 0, 0, 16'h0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0};
    for (int i = 0; i < 2; i++) set_in(i, 0, 0, 0, 0);
    assert_rst();

    // Single read, IDLE tie-break and zero-beat grant
    for (int k = 0; k < 9; k++) begin
      set_in(0, tbl[k].q0, tbl[k].a0, tbl[k].q1, tbl[k].a1);
      #3;
      check("tbl_gnt0", k, gnt[0][0], tbl[k].g0);
      check("tbl_gnt1", k, gnt[0][1], tbl[k].g1);
      check("tbl_owner", k, own[0], tbl[k].ow);
      check("tbl_maddr", k, maddr[0], tbl[k].ma);
      check("tbl_rv0", k, rv[0][0], tbl[k].v0);
      check("tbl_rv1", k, rv[0][1], tbl[k].v1);
      if (tbl[k].v0 || tbl[k].v1)
        check("tbl_rdata", k,
              tbl[k].v1 ? rdata[0][1] : rdata[0][0], tbl[k].rd);
      tick();
    end

    // Both requesting from reset release, burst 8
    assert_rst();
    log_a.delete();
    set_in(0, 1, 0, 1, 100);
    repeat (40) begin
      tick();
      if (log_a[$] == 0)      addr[0][0]++;
      else if (log_a[$] == 1) addr[0][1]++;
    end
    check("sim_idle", 0, log_a[0], -1);
    for (int k = 1; k <= 24; k++)
      check("sim_burst", k, log_a[k], ((k - 1) / 8) % 2);
    set_in(0, 0, 0, 0, 0);
    repeat (4) tick();

    // Lone continuous requester
    rvc = '{'{0, 0}, '{0, 0}};
    log_a.delete();
    set_in(0, 0, 0, 1, 300);
    n   = 0;
    nb  = 0;
    gap = 0;
    while (n < 20 && nb < 60) begin
      tick();
      nb++;
      if (log_a[$] == 1) begin
        n++;
        addr[0][1]++;
      end else if (n > 0) gap++;
    end
    set_in(0, 0, 0, 0, 0);
    repeat (3) tick();
    check("lone_beats", 0, n, 20);
    check("lone_gap", 0, gap, 0);
    check("lone_rv1", 0, rvc[0][1], 20);
    check("lone_rv0", 0, rvc[0][0], 0);

    // Early release of requester 0
    assert_rst();
    rvc = '{'{0, 0}, '{0, 0}};
    log_a.delete();
    set_in(0, 1, 20, 1, 40);
    n  = 0;
    nb = 0;
    while (n < 3 && nb < 20) begin
      tick();
      nb++;
      if (log_a[$] == 0) begin
        n++;
        addr[0][0]++;
      end
    end
    req[0][0] = 1'b0;
    tick();
    check("drop_r1_gnt", 0, gnt[0][1], 1);
    tick();
    tick();
    req[0][1] = 1'b0;
    tick();
    check("drop_rv0", 0, rvc[0][0], 3);
    set_in(0, 1, 60, 1, 70);
    tick();
    check("tie_to_r0", 0, gnt[0][0], 1);
    set_in(0, 0, 0, 0, 0);
    repeat (4) tick();

    // Reset during an accepted beat
    set_in(0, 1, 80, 1, 90);
    nb = 0;
    while (!gnt[0][0] && nb < 20) begin
      tick();
      nb++;
    end
    #2;
    check("pre_rst_acc", 0, gnt[0][0] & req[0][0], 1);
    assert_rst();
    tick();
    check("post_rst_r0", 0, gnt[0][0], 1);
    repeat (3) tick();
    set_in(0, 0, 0, 0, 0);
    repeat (4) tick();

    // Latency 3, burst 1: strict alternation
    assert_rst();
    log_b.delete();
    set_in(1, 1, 200, 1, 300);
    repeat (30) begin
      tick();
      if (log_b[$] == 0)      addr[1][0]++;
      else if (log_b[$] == 1) addr[1][1]++;
    end
    for (int k = 1; k <= 20; k++)
      check("alt_id", k, log_b[k], (k - 1) % 2);
    set_in(1, 0, 0, 0, 0);
    repeat (5) tick();

    // Random traffic on both instances
    repeat (400) begin
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 2; r++) begin
          if (!(req[i][r] && !gnt[i][r]))
            addr[i][r] = 10'($urandom_range(0, 1023));
          req[i][r] = ($urandom_range(0, 3) != 0);
        end
      tick();
    end
    for (int i = 0; i < 2; i++) set_in(i, 0, 0, 0, 0);
    repeat (6) tick();
    check("sb_drained", 0, sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_mem_arbiter.md
Name: char_mem_arbiter

Overview:
- Shares the single synchronous-read packed-ASCII character memory between two read requesters.
- Requester 0 is the transform sequencer's character fetch. Requester 1 is the beacon/callsign text reader.
- Arbitration is round-robin with a bounded burst length, so neither requester can starve the other.
- Read data returns MEM_LATENCY cycles after an accepted beat, tagged to the requester that issued it.

Parameters:
- ADDR_W, 10, memory word address width
- DATA_W, 16, memory word width (two packed ASCII chars)
- MEM_LATENCY, 1, cycles from mem_addr being presented to mem_dout valid; legal range 1..4
- MAX_BURST, 8, maximum accepted beats per grant before re-arbitration; legal range 1..255

Ports:
- clk  in  1  system clock (the divided clock domain the memory runs on)
- rst  in  1  asynchronous, active-high reset
- r0_req  in  1  requester 0 wants a read this cycle
- r0_addr  in  ADDR_W  requester 0 word address; must be stable while r0_req=1 and r0_gnt=0
- r0_gnt  out  1  requester 0 owns the memory; a beat is accepted when r0_req & r0_gnt
- r0_rvalid  out  1  r0_rdata is valid this cycle
- r0_rdata  out  DATA_W  read data for requester 0
- r1_req, r1_addr, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for requester 1
- mem_addr  out  ADDR_W  address to the character memory
- mem_dout  in  DATA_W  character memory read data
- owner  out  2  00 idle, 01 requester 0, 10 requester 1

Behaviour:
- Reset (async assert, released synchronously to clk):
  - r0_gnt = r1_gnt = 0, r0_rvalid = r1_rvalid = 0, owner = 00, mem_addr = 0.
  - Burst counter = 0, last_served = 1 (requester 0 wins the first tie).
  - The in-flight return pipeline is cleared. No rvalid may fire for a beat accepted before reset.
- States: IDLE, GRANT0, GRANT1. Registered state. gnt = (state == GRANTx). owner mirrors state.
- IDLE:
  - No req: stay; mem_addr = 0.
  - One req: go to that requester's GRANT next cycle.
  - Both req: grant the requester != last_served.
  - There is one cycle of latency from req to gnt out of IDLE.
- GRANTx:
  - mem_addr = rx_addr combinationally.
  - Beat accepted in any cycle where rx_req = 1; the burst counter increments.
  - End of grant when rx_req = 0, or when the accepted beat brings the count to MAX_BURST. On end of grant, last_served = x, the counter clears, and the next state is decided the same cycle from the current reqs:
    - other requester requesting: GRANT(other), no bubble cycle;
    - else only x still requesting: GRANTx again with a fresh burst, no gap in gnt;
    - else: IDLE.
  - A grant whose req drops in its first granted cycle accepts zero beats and goes straight to re-arbitration.
- Return path:
  - A MEM_LATENCY-deep shift register of {valid, id}, loaded with {accepted, x} each cycle.
  - Pipeline output with id = 0 drives r0_rvalid; id = 1 drives r1_rvalid.
  - r0_rdata = r1_rdata = mem_dout. Data is only meaningful while the matching rvalid = 1.
  - Returns stay in issue order. Exactly one rvalid pulse per accepted beat. r0_rvalid and r1_rvalid are never high in the same cycle.
- Invariants:
  - r0_gnt and r1_gnt are never both 1.
  - mem_addr changes only at a beat boundary or an ownership change.
  - Counter width is ceil(log2(MAX_BURST+1)).
  - MAX_BURST = 1 gives strict beat-by-beat alternation when both requesters are requesting.

Test Plan:
- Single read after reset. Memory preloaded with word 5 = 0x5C66 ("\f"). r0_req = 1, r0_addr = 5 at cycle t.
  - Required: r0_gnt = 1 at t+1; r0_rvalid = 1 with r0_rdata = 0x5C66 at t+2 (MEM_LATENCY = 1); owner = 01 during the grant.
- Simultaneous requests. r0_req and r1_req held high from reset release; addresses incremented on each accepted beat.
  - Required: r0 gets exactly 8 beats, then r1_gnt = 1 in the very next cycle with no idle gap.
  - Required: r1 gets 8 beats, then r0 again.
  - Required: each accepted address's data returns to the correct requester one cycle later.
- Lone continuous requester. r1 requests for 20 cycles; r0 idle.
  - Required: r1_gnt stays high continuously; 20 r1_rvalid pulses; never an r0 pulse.
- Early release. r0 granted; r0 drops req after 3 accepted beats while r1 is requesting.
  - Required: exactly 3 r0_rvalid pulses; r1_gnt = 1 in the cycle after the drop.
  - Required: the next simultaneous tie goes to r0 (last_served = 1).
- Reset mid-burst. Assert rst in the same cycle as an accepted r0 beat.
  - Required: all outputs reach reset values immediately (async), with no rvalid after reset.
  - Required: on release with both requesting, r0 is granted first.
- Latency parameter. Rerun the simultaneous-request test with MEM_LATENCY = 3 and MAX_BURST = 1.
  - Required: strict alternation; each rvalid arrives exactly 3 cycles after its accepted beat, with the correct id.
